// File: rtl/ym3438_timer_array.sv
// ym3438_timer_array
// ------------------
// Bank of NUM_TIMERS up-counting timers clocked by the shared sample tick.
// Each timer has its own power-of-two prescaler. When a timer advances from
// its maximum count it reloads, raises a one-c1-cycle overflow pulse and,
// if its IRQ enable is set, sets a sticky flag.
//
// Ports:
//   MCLK          master clock
//   IC            asynchronous active-low reset
//   c1            phase enable; state only moves on MCLK edges with c1=1
//   c2            phase enable; not used internally
//   tick_i        sample tick, one c1-qualified cycle per sample
//   load_value_i  reload value, timer i at [CNT_WIDTH*i +: CNT_WIDTH]
//   load_i        run/load bit per timer; a rising edge loads the counter
//   irq_en_i      flag-set enable per timer
//   flag_clr_i    flag clear strobe per timer (a same-edge set wins)
//   flags_o       sticky overflow flags
//   irq_o         OR of flags_o
//   ovf_o         one-c1-cycle overflow pulse per timer
//   cnt_o         current counter values, same packing as load_value_i
//
// Handshake note: there is no valid/ready traffic here. Strobes (tick_i,
// flag_clr_i) are level-sampled on c1 edges only; anything present on a
// non-c1 edge is ignored.
module ym3438_timer_array #(
  parameter int                      NUM_TIMERS = 2,
  parameter int                      CNT_WIDTH  = 10,
  parameter logic [4*NUM_TIMERS-1:0] DIV_LOG2   = {4'd4, 4'd0}
) (
  input  logic                            MCLK,
  input  logic                            IC,
  input  logic                            c1,
  input  logic                            c2,
  input  logic                            tick_i,
  input  logic [NUM_TIMERS*CNT_WIDTH-1:0] load_value_i,
  input  logic [NUM_TIMERS-1:0]           load_i,
  input  logic [NUM_TIMERS-1:0]           irq_en_i,
  input  logic [NUM_TIMERS-1:0]           flag_clr_i,
  output logic [NUM_TIMERS-1:0]           flags_o,
  output logic                            irq_o,
  output logic [NUM_TIMERS-1:0]           ovf_o,
  output logic [NUM_TIMERS*CNT_WIDTH-1:0] cnt_o
);

  // c2 only exists so every OPN2 block has the same phase inputs.
  logic unused_c2;
  assign unused_c2 = c2;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    localparam int D  = int'(DIV_LOG2[4*i +: 4]);
    // A divide-by-one timer still gets a 1-bit prescaler that simply
    // stays at zero, which keeps the register declaration legal.
    localparam int PW = (D > 0) ? D : 1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic                 load_d_q;
    logic                 flag_q, flag_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] lv;
    logic                 rise, run, adv, set;

    assign lv = load_value_i[CNT_WIDTH*i +: CNT_WIDTH];

    always_comb begin
      cnt_d = cnt_q;
      pre_d = pre_q;
      ovf_d = 1'b0;
      adv   = 1'b0;
      set   = 1'b0;
      rise  = load_i[i] & ~load_d_q;
      run   = load_i[i] & load_d_q & tick_i;

      if (rise) begin
        // Loading takes the whole cycle: no count even if a tick is present.
        cnt_d = lv;
        pre_d = '0;
      end else if (run) begin
        if (D == 0) begin
          adv = 1'b1;
        end else begin
          pre_d = pre_q + PW'(1);
          adv   = (pre_d == '0);
        end
      end

      if (adv) begin
        if (cnt_q == '1) begin
          // Reload uses whatever load value is present right now.
          cnt_d = lv;
          ovf_d = 1'b1;
          set   = irq_en_i[i];
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      if (set) begin
        flag_d = 1'b1;
      end else if (flag_clr_i[i]) begin
        flag_d = 1'b0;
      end else begin
        flag_d = flag_q;
      end
    end

    always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
        cnt_q    <= '0;
        pre_q    <= '0;
        load_d_q <= 1'b0;
        flag_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (c1) begin
        cnt_q    <= cnt_d;
        pre_q    <= pre_d;
        load_d_q <= load_i[i];
        flag_q   <= flag_d;
        ovf_q    <= ovf_d;
      end
    end

    assign cnt_o[CNT_WIDTH*i +: CNT_WIDTH] = cnt_q;
    assign flags_o[i]                      = flag_q;
    assign ovf_o[i]                        = ovf_q;
  end

  assign irq_o = |flags_o;

endmodule

// File: tb/tb_ym3438_timer_array.sv
// Bench for ym3438_timer_array (default parameters: 2 timers, 10 bits,
// timer0 /1, timer1 /16). A model tracks each timer as a single position
// count in prescaled ticks; a compare process checks every output on every
// falling MCLK edge, and directed literal checks pin key points.
module tb_ym3438_timer_array;
  localparam int NT = 2;
  localparam int CW = 10;

  logic          MCLK, IC, c1, c2, tick;
  logic [NT*CW-1:0] lv;
  logic [NT-1:0] load, en, clr;
  logic [NT-1:0] flags_o, ovf_o;
  logic          irq_o;
  logic [NT*CW-1:0] cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  ym3438_timer_array #(
    .NUM_TIMERS(NT),
    .CNT_WIDTH (CW),
    .DIV_LOG2  ({4'd4, 4'd0})
  ) dut (
    .MCLK        (MCLK),
    .IC          (IC),
    .c1          (c1),
    .c2          (c2),
    .tick_i      (tick),
    .load_value_i(lv),
    .load_i      (load),
    .irq_en_i    (en),
    .flag_clr_i  (clr),
    .flags_o     (flags_o),
    .irq_o       (irq_o),
    .ovf_o       (ovf_o),
    .cnt_o       (cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  // c1 and c2 alternate every MCLK cycle, so half the rising edges are
  // non-c1 edges.
  initial begin
    c1 = 1'b0;
    c2 = 1'b1;
    forever begin
      @(negedge MCLK);
      c1 = ~c1;
      c2 = ~c1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos[i] = counter * 2^div + prescaler phase. Every tick adds one; reaching
  // 2^(CW+div) is an overflow and the position restarts at reload * 2^div.
  int dv[NT] = '{0, 4};
  int pos[NT];
  bit m_ld[NT];
  bit m_flg[NT];
  bit m_ovf[NT];

  always @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int i = 0; i < NT; i++) begin
        pos[i] = 0; m_ld[i] = 0; m_flg[i] = 0; m_ovf[i] = 0;
      end
    end else if (c1) begin
      for (int i = 0; i < NT; i++) begin
        int v;
        bit s;
        v = int'(lv[CW*i +: CW]);
        s = 0;
        m_ovf[i] = 0;
        if (load[i] && !m_ld[i]) begin
          pos[i] = v << dv[i];
        end else if (load[i] && tick) begin
          pos[i] = pos[i] + 1;
          if (pos[i] == (1 << (CW + dv[i]))) begin
            pos[i]   = v << dv[i];
            m_ovf[i] = 1;
            s        = en[i];
          end
        end
        if (s) m_flg[i] = 1;
        else if (clr[i]) m_flg[i] = 0;
        m_ld[i] = load[i];
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge MCLK) begin
    bit any;
    any = 0;
    for (int i = 0; i < NT; i++) begin
      check($sformatf("model_cnt%0d", i), 32'(cnt_o[CW*i +: CW]), 32'(pos[i] >> dv[i]));
      check($sformatf("model_ovf%0d", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
      check($sformatf("model_flag%0d", i), 32'(flags_o[i]), 32'(m_flg[i]));
      any = any | m_flg[i];
    end
    check("model_irq", 32'(irq_o), 32'(any));
  end

  // ---------------- driver tasks ----------------
  // One step spans two MCLK edges: exactly one c1 edge and one non-c1 edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge MCLK);
      @(negedge MCLK);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    IC = 1'b0; tick = 1'b0; lv = '0; load = '0; en = '0; clr = '0;
    step(2);
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    IC = 1'b1;
    step(1);

    // Timer0 basic: 1020 -> overflow on the 4th tick.
    lv[9:0] = 10'd1020; en = 2'b01; load = 2'b01;
    step(1);
    check("t0_load_cnt", 32'(cnt_o[9:0]), 32'd1020);
    for (int k = 1; k <= 6; k++) begin
      pulse_tick();
      check("t0_ovf", 32'(ovf_o[0]), 32'(k == 4));
      if (k == 4) begin
        check("t0_reload_cnt", 32'(cnt_o[9:0]), 32'd1020);
        check("t0_flag", 32'(flags_o[0]), 32'd1);
        check("t0_irq", 32'(irq_o), 32'd1);
      end
      step(23);
    end

    // Timer1 prescale: 1022 at /16 -> overflow every 32 ticks; timer0 stopped.
    lv[19:10] = 10'd1022; en = 2'b11; load = 2'b10;
    step(1);
    for (int k = 1; k <= 64; k++) begin
      pulse_tick();
      check("t1_ovf", 32'(ovf_o[1]), 32'((k % 32) == 0));
      check("t1_t0_quiet", 32'(ovf_o[0]), 32'd0);
      step(1);
    end
    check("t0_hold_cnt", 32'(cnt_o[9:0]), 32'd1022);

    // Flag priority: clear held across the overflow edge.
    lv[9:0] = 10'd1022; load = 2'b01;
    step(1);
    pulse_tick();
    step(1);
    clr = 2'b01;
    pulse_tick();
    check("prio_ovf", 32'(ovf_o[0]), 32'd1);
    check("prio_flag_set_wins", 32'(flags_o[0]), 32'd1);
    step(1);
    check("prio_flag_cleared", 32'(flags_o[0]), 32'd0);
    check("prio_flag1_kept", 32'(flags_o[1]), 32'd1);
    clr = 2'b10;
    step(1);
    clr = 2'b00;
    check("prio_all_clear", 32'(flags_o), 32'd0);

    // IRQ disabled, load value at max: overflow on every tick, no flags.
    en = 2'b00; load = 2'b00;
    step(1);
    lv[9:0] = 10'd1023; load = 2'b01;
    step(1);
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      check("noirq_ovf", 32'(ovf_o[0]), 32'd1);
      check("noirq_flags", 32'(flags_o), 32'd0);
      check("noirq_irq", 32'(irq_o), 32'd0);
      step(1);
      check("noirq_ovf_gone", 32'(ovf_o[0]), 32'd0);
    end

    // Stop / restart.
    load = 2'b00;
    step(1);
    lv[9:0] = 10'd1000; load = 2'b01;
    step(1);
    repeat (2) begin pulse_tick(); step(1); end
    check("stop_run_cnt", 32'(cnt_o[9:0]), 32'd1002);
    load = 2'b00;
    repeat (5) begin pulse_tick(); step(1); end
    check("stop_hold_cnt", 32'(cnt_o[9:0]), 32'd1002);
    load = 2'b01;
    step(1);
    check("restart_cnt", 32'(cnt_o[9:0]), 32'd1000);

    // Build cnt0=1010 with both flags set, using a live reload change.
    load = 2'b00;
    step(1);
    lv[9:0] = 10'd1023; lv[19:10] = 10'd1023; en = 2'b11; load = 2'b11;
    step(1);
    lv[9:0] = 10'd995;
    pulse_tick();
    check("live_reload_cnt", 32'(cnt_o[9:0]), 32'd995);
    step(1);
    repeat (15) begin pulse_tick(); step(1); end
    check("pre_rst_cnt0", 32'(cnt_o[9:0]), 32'd1010);
    check("pre_rst_flags", 32'(flags_o), 32'd3);

    // Asynchronous reset mid-operation.
    @(posedge MCLK);
    #3;
    IC = 1'b0;
    #1;
    check("midrst_cnt", 32'(cnt_o), 32'd0);
    check("midrst_flags", 32'(flags_o), 32'd0);
    check("midrst_ovf", 32'(ovf_o), 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    load = 2'b01; lv[9:0] = 10'd777;
    step(2);
    IC = 1'b1;
    step(1);
    check("post_rst_cnt0", 32'(cnt_o[9:0]), 32'd777);
    check("post_rst_cnt1", 32'(cnt_o[19:10]), 32'd0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ym3438_timer_array.md
Name: ym3438_timer_array

Overview:
- Parametrised timer bank for the OPN2 core. It supplies the timer A/B overflow flags to ym3438_io (today tied to 0) and the CSM key-on trigger to ym3438_reg_ctrl.
- Generalises the fixed two-timer arrangement: NUM_TIMERS up-counters of CNT_WIDTH bits, each with its own power-of-two prescale on the shared sample tick.
- Provides per-timer IRQ enable, sticky flags and one-cycle overflow pulses.

Parameters:
- NUM_TIMERS, 2: number of independent timers.
- CNT_WIDTH, 10: counter width; maximum count is 2^CNT_WIDTH-1.
- DIV_LOG2, {4'd4,4'd0}: packed 4 bits per timer, timer i at [4i+3:4i]. Timer i advances once every 2^DIV_LOG2[i] ticks. The default gives timer0 /1 and timer1 /16.

Ports:
- MCLK  in  1  master clock
- IC  in  1  asynchronous active-low reset
- c1  in  1  phase enable; all state updates only on MCLK rising edges where c1=1
- c2  in  1  phase enable; unused internally, present for port uniformity
- tick_i  in  1  sample tick (fsm_timer_ed); one c1-qualified cycle per sample
- load_value_i  in  NUM_TIMERS*CNT_WIDTH  reload value, timer i at [CNT_WIDTH*i +: CNT_WIDTH]
- load_i  in  NUM_TIMERS  run/load bit per timer (reg 0x27 LOAD bits)
- irq_en_i  in  NUM_TIMERS  flag-set enable per timer
- flag_clr_i  in  NUM_TIMERS  flag clear strobe per timer
- flags_o  out  NUM_TIMERS  sticky overflow flags (status read bits)
- irq_o  out  1  OR of flags_o
- ovf_o  out  NUM_TIMERS  one-c1-cycle overflow pulse, independent of irq_en
- cnt_o  out  NUM_TIMERS*CNT_WIDTH  current counter values (debug/test)

Behaviour:
- Reset (IC=0, async): all counters 0, prescalers 0, load_d 0, flags_o 0, ovf_o 0, irq_o 0. All outputs hold these values while IC=0.
- Per timer i, every c1 edge:
  - load_d[i] <= load_i[i].
  - Rising load (load_i=1, load_d=0): counter <= load_value, prescaler <= 0. No count happens that cycle.
  - Loaded (load_i=1 and load_d=1) with tick_i=1: prescaler increments modulo 2^DIV_LOG2[i].
  - Advance: the prescaler wraps to 0, or DIV_LOG2[i]=0 (every tick advances).
  - Advance with counter != max: counter <= counter+1.
  - Advance with counter == max: counter <= load_value (reload sampled live), ovf_o[i] pulses 1 for exactly one c1 cycle, and flags_o[i] <= 1 if irq_en_i[i]=1.
  - Stopped (load_i=0): counter and prescaler hold their values; no overflow is possible.
  - load_value changes while running affect only the next load or reload.
- Flags:
  - flag_clr_i[i]=1 clears flags_o[i].
  - Simultaneous set and clear on the same edge: set wins, flag stays 1.
  - Dropping irq_en_i does not clear an existing flag.
- irq_o is combinational OR of flags_o.
- Non-c1 edges: no state change; tick_i is ignored when c1=0.
- Period: timer i overflows every (2^CNT_WIDTH - load_value) * 2^DIV_LOG2[i] ticks after start. The first overflow occurs after exactly that many ticks, counted from the first tick after the rising load.
- load_value = max: overflow on every advance.
- load_value = 0: full-range period.
- Reset mid-count aborts everything. After IC deasserts, load_i already high is treated as a rising load, because load_d resets to 0.
- Widths: reload and compare are CNT_WIDTH bits with no sign or saturation. Prescaler width is max(DIV_LOG2[i],1).

Test Plan:
- Timer0 basic: NUM_TIMERS=2, CNT_WIDTH=10, load_value0=1020, irq_en0=1, load0 0->1, then 1 tick per 24 c1 cycles. Required: ovf_o[0] pulses on the 4th tick after load; flags_o[0]=1 and irq_o=1 from that edge on; counter reads 1020 again.
- Timer1 prescale: load_value1=1022, irq_en1=1. Required: first ovf_o[1] on tick 32 after load, then every 32 ticks; ovf_o[0] stays 0.
- Flag priority: hold flag_clr_i[0]=1 across the overflow edge. Required: flags_o[0]=1 after that edge; clear on the next cycle with no overflow gives flags_o[0]=0.
- IRQ disabled: irq_en0=0, load_value0=1023, run 3 ticks. Required: ovf_o[0] pulses 3 times; flags_o=0, irq_o=0.
- Stop/restart: load0 high for 2 ticks at load_value 1000 (cnt=1002), load0 low for 5 ticks, then high. Required: cnt stays 1002 while low, then reloads to 1000 on the rising edge.
- Reset mid-operation: assert IC=0 between c1 edges while cnt0=1010 and flags_o=2'b11. Required: all outputs 0 immediately; after release with load_i=2'b01 held, cnt0=load_value0 on the first c1 edge.
